// File: rtl/rv32i_opcodes.sv
// rtl/rv32i_opcodes.sv - shared RV32I opcode encodings and constants
package rv32i_opcodes;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rv32i_opcode_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I multicycle instruction fetch stage
//
// Holds the fetch PC, issues one-word requests to instruction memory, captures
// the returned word and presents inst/pc/opcode to the controller. Redirects
// reload the fetch PC; a response made stale by a redirect is discarded.
// A misaligned redirect target locks the stage in FAULT until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_req           controller asks for the next instruction
//   redirect/redirect_pc  branch/jump target load
//   inst_valid/inst/opcode/pc/pc_plus4  instruction presented to controller
//   fetch_fault         sticky misaligned-redirect flag
//   imem_req/imem_addr  single-cycle read request to instruction memory
//   imem_rvalid/imem_rdata  read response
module instr_fetch
    import rv32i_opcodes::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic                redirect,
    input  logic [WIDTH-1:0]    redirect_pc,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output rv32i_opcode_t       opcode,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus4,
    output logic                fetch_fault,
    output logic                imem_req,
    output logic [WIDTH-1:0]    imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_FLUSH,
        ST_FAULT
    } fetch_state_t;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    fetch_state_t     state;
    fetch_state_t     state_nx;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_nx;
    logic             capture;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            inst        <= RV32I_NOP;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            fetch_fault <= (state_nx == ST_FAULT);
            if (capture) begin
                inst <= imem_rdata;
                pc   <= fetch_pc;
            end
        end
    end

    // Next state. A redirect outranks fetch_req and any response arriving in
    // the same cycle; the redirected request is issued on a later fetch_req.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        capture     = 1'b0;
        if (redirect && state != ST_FAULT) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_nx = ST_FAULT;
            end else begin
                fetch_pc_nx = redirect_pc;
                case (state)
                    ST_WAIT, ST_FLUSH: state_nx = imem_rvalid ? ST_IDLE : ST_FLUSH;
                    default:           state_nx = ST_IDLE;
                endcase
            end
        end else begin
            case (state)
                ST_IDLE: if (fetch_req) state_nx = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        capture     = 1'b1;
                        fetch_pc_nx = fetch_pc + PC_STEP;
                        state_nx    = ST_HOLD;
                    end
                end
                ST_HOLD:  if (fetch_req) state_nx = ST_WAIT;
                ST_FLUSH: if (imem_rvalid) state_nx = ST_IDLE;
                default:  state_nx = ST_FAULT;
            endcase
        end
    end

    // Outputs. imem_req is the only combinational input-to-output path.
    always_comb begin
        inst_valid = (state == ST_HOLD);
        imem_req   = fetch_req && !redirect && (state == ST_IDLE || state == ST_HOLD);
        imem_addr  = fetch_pc;
        pc_plus4   = pc + PC_STEP;
        opcode     = rv32i_opcode_t'(inst[6:0]);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
    import rv32i_opcodes::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic          inst_valid, fetch_fault, imem_req;
    logic [31:0]   inst, pc, pc_plus4, imem_addr;
    rv32i_opcode_t opcode;

    logic          w_inst_valid, w_fetch_fault, w_imem_req;
    logic [31:0]   w_inst, w_pc, w_pc_plus4, w_imem_addr;
    rv32i_opcode_t w_opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata)
    );

    instr_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(w_inst_valid), .inst(w_inst),
        .opcode(w_opcode), .pc(w_pc), .pc_plus4(w_pc_plus4), .fetch_fault(w_fetch_fault),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_req = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Issue fetch_req in a request-capable state, answer after lat cycles,
    // and check request address, latency edge and captured instruction.
    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input int lat);
        fetch_req = 1'b1;
        #1;
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        tick();
        fetch_req = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, inst_valid}, 32'd0);
        for (int i = 1; i < lat; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        #1;
        chk({tag, "_valid_early"}, {31'b0, inst_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, "_inst"}, inst, data);
        chk({tag, "_pc"}, pc, addr);
        chk({tag, "_pc4"}, pc_plus4, addr + 32'd4);
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);

        // Single fetch, L=1
        do_fetch("f1", 32'h0, 32'h0050_0093, 1);
        chk("f1_opcode", {25'b0, opcode}, {25'b0, OP_IMM});
        tick();
        chk("f1_hold", {31'b0, inst_valid}, 32'd1);

        // Three sequential fetches, L=3
        do_reset();
        do_fetch("s0", 32'h0, 32'h1111_1013, 3);
        do_fetch("s1", 32'h4, 32'h2222_2013, 3);
        do_fetch("s2", 32'h8, 32'h3333_3013, 3);

        // Redirect while waiting: stale response discarded
        do_reset();
        do_fetch("r0", 32'h0, 32'h0050_0093, 1);
        fetch_req = 1'b1;
        #1;
        chk("r_req4", imem_addr, 32'h4);
        tick();
        fetch_req = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        fetch_req = 1'b1;
        #1;
        chk("flush_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        fetch_req = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_inst", inst, 32'h0050_0093);
        chk("stale_valid", {31'b0, inst_valid}, 32'd0);
        do_fetch("r1", 32'h100, 32'h0000_0073, 2);

        // Redirect with same-cycle response, then redirect with fetch_req
        fetch_req = 1'b1;
        #1;
        chk("rr_addr", imem_addr, 32'h104);
        tick();
        fetch_req = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA;
        tick();
        imem_rvalid = 1'b0;
        chk("rr_inst", inst, 32'h0000_0073);
        chk("rr_valid", {31'b0, inst_valid}, 32'd0);
        redirect_pc = 32'h300; fetch_req = 1'b1;
        #1;
        chk("rf_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        fetch_req = 1'b0;
        do_fetch("rf", 32'h300, 32'h0000_006F, 1);
        chk("rf_opcode", {25'b0, opcode}, {25'b0, OP_JAL});

        // Misaligned redirect: sticky fault, no requests, reset clears
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("flt_set", {31'b0, fetch_fault}, 32'd1);
        chk("flt_valid", {31'b0, inst_valid}, 32'd0);
        fetch_req = 1'b1;
        #1;
        chk("flt_noreq", {31'b0, imem_req}, 32'd0);
        tick(); tick();
        chk("flt_sticky", {31'b0, fetch_fault}, 32'd1);
        chk("flt_noreq2", {31'b0, imem_req}, 32'd0);
        fetch_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("flt_async_clr", {31'b0, fetch_fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        fetch_req = 1'b1;
        #1;
        chk("flt_rst_req", {31'b0, imem_req}, 32'd1);
        chk("flt_rst_addr", imem_addr, 32'h0);

        // Async reset mid-WAIT; late response ignored in IDLE
        tick();
        fetch_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_inst", inst, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        chk("wrst_valid", {31'b0, inst_valid}, 32'd0);
        chk("wrst_inst2", inst, 32'h0000_0013);

        // Wraparound instance
        do_reset();
        #1;
        chk("w_rst_pc4", w_pc_plus4, 32'h0);
        fetch_req = 1'b1;
        #1;
        chk("w0_req", {31'b0, w_imem_req}, 32'd1);
        chk("w0_addr", w_imem_addr, 32'hFFFF_FFFC);
        tick();
        fetch_req = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0037;
        tick();
        imem_rvalid = 1'b0;
        chk("w0_valid", {31'b0, w_inst_valid}, 32'd1);
        chk("w0_pc", w_pc, 32'hFFFF_FFFC);
        chk("w0_pc4", w_pc_plus4, 32'h0);
        chk("w0_opcode", {25'b0, w_opcode}, {25'b0, OP_LUI});
        fetch_req = 1'b1;
        #1;
        chk("w1_addr", w_imem_addr, 32'h0);
        tick();
        fetch_req = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        chk("w1_pc", w_pc, 32'h0);
        chk("w1_fault", {31'b0, w_fetch_fault}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle RV32I core, directly upstream of the controller. Holds the fetch PC, issues single-word requests to instruction memory over a variable-latency request/response interface, captures the returned word in the instruction register, and presents the instruction, its PC and its opcode to the controller. It also accepts PC redirects from branch/jump resolution, discards any in-flight response that a redirect makes stale, and flags misaligned targets.

## Interface
- WIDTH, 32, address/PC width in bits.
- RESET_PC, 0, fetch address after reset.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  controller requests the next instruction; consumes the held one.
- redirect  in  1  load `redirect_pc` as the next fetch address.
- redirect_pc  in  WIDTH  redirect target.
- inst_valid  out  1  `inst`, `pc` and `opcode` are valid.
- inst  out  32  instruction register.
- opcode  out  rv32i_opcode_t  `inst[6:0]`.
- pc  out  WIDTH  address of `inst`.
- pc_plus4  out  WIDTH  `pc + 4`, modulo 2^WIDTH.
- fetch_fault  out  1  sticky misaligned-redirect flag.
- imem_req  out  1  single-cycle read request.
- imem_addr  out  WIDTH  request address; meaningful only while `imem_req` is high.
- imem_rvalid  in  1  response strobe.
- imem_rdata  in  32  response data; valid only with `imem_rvalid`.

## Operation
- **Memory protocol**
  - Memory accepts a request in the cycle `imem_req` is high; there is no stall.
  - Exactly one `imem_rvalid` returns per request, at least 1 cycle later.
  - At most one request is outstanding.
- **Addressing:** `imem_addr` is driven combinationally from the internal `fetch_pc`.
- **IDLE**
  - `inst_valid` = 0.
  - On `fetch_req`: `imem_req` = 1, go to WAIT.
- **WAIT**
  - On `imem_rvalid`: `inst` <= `imem_rdata`, `pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc + 4`, go to HOLD.
- **HOLD**
  - `inst_valid` = 1.
  - On `fetch_req`: issue the next request the same cycle (`imem_req` = 1), go to WAIT.
  - `inst`/`pc` keep their values until overwritten, but `inst_valid` drops.
- **FLUSH**
  - A stale response is outstanding.
  - On `imem_rvalid`: discard the data, go to IDLE.
- **FAULT**
  - Absorbing; ignores all inputs until reset.
  - `fetch_fault` = 1, `inst_valid` = 0, `imem_req` = 0.
- **Redirect (any state except FAULT)**
  - `fetch_pc` <= `redirect_pc`.
  - IDLE/HOLD go to IDLE.
  - WAIT without `imem_rvalid` goes to FLUSH.
  - WAIT with `imem_rvalid` in the same cycle: discard the response, go to IDLE.
  - FLUSH with `imem_rvalid`: go to IDLE. FLUSH without `imem_rvalid`: stay in FLUSH.
  - If `redirect_pc[1:0]` != 0: go to FAULT instead, `fetch_pc` unchanged.
- **Simultaneous `redirect` and `fetch_req`:** redirect wins; `fetch_req` is ignored that cycle and must be re-asserted.
- **Stray response:** `imem_rvalid` in IDLE/HOLD/FAULT is a protocol violation; it is ignored and no state changes.
- **Arithmetic:** all PC arithmetic is unsigned and wraps modulo 2^WIDTH. `fetch_pc` = 2^WIDTH-4 increments to 0 with no flag.
- **Reset values**
  - state IDLE.
  - `fetch_pc` = `pc` = RESET_PC.
  - `inst` = 32'h0000_0013 (NOP).
  - `inst_valid` = 0, `imem_req` = 0, `fetch_fault` = 0.

## Timing
- `imem_req` is combinational from `fetch_req` and state. This is the only input-to-output path.
- Latency: `fetch_req` in cycle t and `imem_rvalid` in cycle t+L give `inst_valid` = 1 from cycle t+L+1.
- Back-to-back throughput: one instruction per L+1 cycles.
- A redirect takes effect on the next request; the first redirected request can issue the cycle after the redirect, at the earliest.
- `inst_valid` falls in the cycle after `fetch_req` is sampled in HOLD, or after a redirect.
- An asynchronous reset mid-WAIT immediately returns to reset values. A response arriving after deassertion hits IDLE and is ignored.

## Structure
- `rv32i_opcode_t` and the new constant `RV32I_NOP` (32'h0000_0013) live in the shared `rv32i_opcodes` package.
- The fetch state enum (IDLE, WAIT, HOLD, FLUSH, FAULT) stays local to the module.
- Single module, no sub-modules. Registers are `state`, `fetch_pc`, `pc`, `inst`, `fetch_fault`.

## Test plan
- Reset, then `fetch_req` with L=1 and `imem_rdata`=32'h00500093 → `imem_req` with addr 0 at t, `inst_valid` at t+2, `pc`=0, `opcode`=OP_IMM, `pc_plus4`=4.
- Three sequential fetches with L=3 → addresses 0, 4, 8; each `inst_valid` 4 cycles after its `fetch_req`.
- Redirect to 0x100 while WAIT at addr 4, stale response 32'hDEADBEEF two cycles later → `inst` unchanged, `inst_valid`=0, next request addr 0x100.
- Redirect and `imem_rvalid` in the same cycle, and redirect and `fetch_req` in the same cycle → response dropped, no `imem_req` that cycle, next request at the target.
- Redirect to 0x102 → `fetch_fault`=1; later `fetch_req` produces no `imem_req`; deassert `rst_n` → fault clears, `fetch_pc`=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, two fetches → addresses FFFF_FFFC then 0; `pc_plus4`=0 for the first.
